hazard_ctrl: RTL and testbench



---
 rtl/hazard_pkg.sv | 18 +
 rtl/forward_sel.sv | 23 ++
 rtl/hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forward selects,
// the load result-source code and the data-memory wait states.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/forward_sel.sv
// Combinational bypass select for one E-stage source operand.
// The M-stage result is newer than W, so it wins when both match.
module forward_sel
    import hazard_pkg::*;
(
    input  logic [4:0] rs_i,
    input  logic [4:0] rd_m_i,
    input  logic       reg_write_m_i,
    input  logic [4:0] rd_w_i,
    input  logic       reg_write_w_i,
    output fwd_sel_t   fwd_o
);

    always_comb begin
        fwd_o = FWD_RF;
        if (reg_write_m_i && (rd_m_i != 5'd0) && (rd_m_i == rs_i)) begin
            fwd_o = FWD_M;
        end else if (reg_write_w_i && (rd_w_i != 5'd0) && (rd_w_i == rs_i)) begin
            fwd_o = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forward control for the 5-stage core, with a data-memory wait
// FSM that holds M for MEM_LATENCY cycles and saturating event counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           Rs1D,
    input  logic [4:0]           Rs2D,
    input  logic [4:0]           Rs1E,
    input  logic [4:0]           Rs2E,
    input  logic [4:0]           RdE,
    input  logic [4:0]           RdM,
    input  logic [4:0]           RdW,
    input  logic [1:0]           ResultSrcE,
    input  logic                 RegWriteM,
    input  logic                 RegWriteW,
    input  logic                 PCSrcE,
    input  logic                 MemReqM,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 StallE,
    output logic                 StallM,
    output logic                 FlushD,
    output logic                 FlushE,
    output logic                 FlushW,
    output logic [1:0]           ForwardAE,
    output logic [1:0]           ForwardBE,
    output logic [CNT_WIDTH-1:0] StallCycles,
    output logic [CNT_WIDTH-1:0] FlushCount,
    output logic [CNT_WIDTH-1:0] LoadUseCount
);

    localparam bit                   MULTI_CYCLE = (MEM_LATENCY > 1);
    localparam logic [3:0]           WAIT_INIT   = MULTI_CYCLE ? 4'(MEM_LATENCY - 2) : 4'd0;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;

    fwd_sel_t   fwd_a;
    fwd_sel_t   fwd_b;
    logic       lw_stall;
    logic       mem_stall;
    mem_state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_WIDTH-1:0] lu_cnt_q, lu_cnt_d;

    forward_sel u_fwd_a (
        .rs_i          (Rs1E),
        .rd_m_i        (RdM),
        .reg_write_m_i (RegWriteM),
        .rd_w_i        (RdW),
        .reg_write_w_i (RegWriteW),
        .fwd_o         (fwd_a)
    );

    forward_sel u_fwd_b (
        .rs_i          (Rs2E),
        .rd_m_i        (RdM),
        .reg_write_m_i (RegWriteM),
        .rd_w_i        (RdW),
        .reg_write_w_i (RegWriteW),
        .fwd_o         (fwd_b)
    );

    assign ForwardAE = fwd_a;
    assign ForwardBE = fwd_b;

    assign lw_stall = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != 5'd0) &&
                      ((Rs1D == RdE) || (Rs2D == RdE));

    // WAIT with cnt==0 is the access's last cycle: M is released while the
    // FSM returns to IDLE, so a following memory op pays its full latency.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_stall = 1'b0;
        case (state_q)
            IDLE: begin
                if (MemReqM && MULTI_CYCLE) begin
                    mem_stall = 1'b1;
                    state_d   = WAIT;
                    cnt_d     = WAIT_INIT;
                end
            end
            WAIT: begin
                mem_stall = (cnt_q != 4'd0);
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        StallF = mem_stall || lw_stall;
        StallD = mem_stall || lw_stall;
        StallE = mem_stall;
        StallM = mem_stall;
        FlushW = mem_stall;
        FlushD = !mem_stall && PCSrcE;
        FlushE = !mem_stall && (lw_stall || PCSrcE);
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        lu_cnt_d    = lu_cnt_q;
        if ((mem_stall || lw_stall) && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
        if (PCSrcE && !mem_stall && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
        end
        if (lw_stall && !mem_stall && (lu_cnt_q != CNT_MAX)) begin
            lu_cnt_d = lu_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            lu_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            lu_cnt_q    <= lu_cnt_d;
        end
    end

    assign StallCycles  = stall_cnt_q;
    assign FlushCount   = flush_cnt_q;
    assign LoadUseCount = lu_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: one instance with a 3-cycle memory and 8-bit
// counters, one with a single-cycle memory, both against a cycle model.
module tb_hazard_ctrl;

    localparam int LAT  = 3;
    localparam int CMAX = 255;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0] ResultSrcE;
    logic       RegWriteM, RegWriteW, PCSrcE, MemReqM;

    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0] ForwardAE, ForwardBE;
    logic [7:0] StallCycles, FlushCount, LoadUseCount;

    logic        StallF1, StallD1, StallE1, StallM1, FlushD1, FlushE1, FlushW1;
    logic [1:0]  ForwardAE1, ForwardBE1;
    logic [31:0] StallCycles1, FlushCount1, LoadUseCount1;

    hazard_ctrl #(.MEM_LATENCY(LAT), .CNT_WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE), .MemReqM(MemReqM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallCycles(StallCycles), .FlushCount(FlushCount), .LoadUseCount(LoadUseCount)
    );

    hazard_ctrl #(.MEM_LATENCY(1), .CNT_WIDTH(32)) dut1 (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE), .MemReqM(MemReqM),
        .StallF(StallF1), .StallD(StallD1), .StallE(StallE1), .StallM(StallM1),
        .FlushD(FlushD1), .FlushE(FlushE1), .FlushW(FlushW1),
        .ForwardAE(ForwardAE1), .ForwardBE(ForwardBE1),
        .StallCycles(StallCycles1), .FlushCount(FlushCount1), .LoadUseCount(LoadUseCount1)
    );

    int total = 0;
    int bad   = 0;

    // Model: position of the current access within its LAT cycles in M
    // (0 = no access), plus event counts for both instances.
    int          pos = 0;
    int          sc = 0, fc = 0, lc = 0;
    int unsigned sc1 = 0, fc1 = 0, lc1 = 0;

    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic [1:0] rse;
        logic       rwm, rww, pcs;
        logic [1:0] fa, fb;
        logic       sf, fd, fe;
    } vec_t;

    vec_t vecs[10];
    int   vec_idx = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwd(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic clear_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        ResultSrcE = 0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0; MemReqM = 0;
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic step();
        int   cur;
        bit   ms, lw, pc;
        logic [1:0] fa, fb;
        @(negedge clk);
        cur = pos;
        if (cur == 0 && MemReqM) cur = 1;
        ms = (cur >= 1) && (cur < LAT);
        lw = (ResultSrcE == 2'b01) && (RdE != 0) && (Rs1D == RdE || Rs2D == RdE);
        pc = PCSrcE;
        fa = fwd(Rs1E);
        fb = fwd(Rs2E);

        chk("fwdA",   32'(ForwardAE), 32'(fa));
        chk("fwdB",   32'(ForwardBE), 32'(fb));
        chk("stallF", 32'(StallF), 32'(ms | lw));
        chk("stallD", 32'(StallD), 32'(ms | lw));
        chk("stallE", 32'(StallE), 32'(ms));
        chk("stallM", 32'(StallM), 32'(ms));
        chk("flushW", 32'(FlushW), 32'(ms));
        chk("flushD", 32'(FlushD), 32'(!ms && pc));
        chk("flushE", 32'(FlushE), 32'(!ms && (lw || pc)));
        chk("stallCycles",  32'(StallCycles),  32'(sc));
        chk("flushCount",   32'(FlushCount),   32'(fc));
        chk("loadUseCount", 32'(LoadUseCount), 32'(lc));

        chk("l1_fwdA",   32'(ForwardAE1), 32'(fa));
        chk("l1_stallF", 32'(StallF1), 32'(lw));
        chk("l1_stallM", 32'(StallM1), 32'(0));
        chk("l1_flushW", 32'(FlushW1), 32'(0));
        chk("l1_flushE", 32'(FlushE1), 32'(lw || pc));
        chk("l1_stallCycles",  StallCycles1,  sc1);
        chk("l1_flushCount",   FlushCount1,   fc1);
        chk("l1_loadUseCount", LoadUseCount1, lc1);

        if (vec_idx >= 0) begin
            chk("vec_fwdA",   32'(ForwardAE), 32'(vecs[vec_idx].fa));
            chk("vec_fwdB",   32'(ForwardBE), 32'(vecs[vec_idx].fb));
            chk("vec_stallF", 32'(StallF), 32'(vecs[vec_idx].sf));
            chk("vec_flushD", 32'(FlushD), 32'(vecs[vec_idx].fd));
            chk("vec_flushE", 32'(FlushE), 32'(vecs[vec_idx].fe));
        end

        @(posedge clk);
        if (reset) begin
            pos = 0; sc = 0; fc = 0; lc = 0; sc1 = 0; fc1 = 0; lc1 = 0;
        end else begin
            if ((ms || lw) && sc < CMAX) sc++;
            if (pc && !ms && fc < CMAX) fc++;
            if (lw && !ms && lc < CMAX) lc++;
            if (lw) sc1++;
            if (pc) fc1++;
            if (lw) lc1++;
            pos = (cur == LAT || cur == 0) ? 0 : cur + 1;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        //            rs1d rs2d rs1e rs2e rde rdm rdw rse  rwm rww pcs  fa     fb     sf fd fe
        vecs[0] = '{0, 0, 5, 5, 0, 5, 5, 2'b00, 1, 1, 0, 2'b10, 2'b10, 0, 0, 0};
        vecs[1] = '{0, 0, 5, 5, 0, 0, 5, 2'b00, 1, 1, 0, 2'b01, 2'b01, 0, 0, 0};
        vecs[2] = '{0, 0, 5, 5, 0, 0, 5, 2'b00, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0};
        vecs[3] = '{0, 0, 3, 9, 0, 3, 9, 2'b00, 1, 1, 0, 2'b10, 2'b01, 0, 0, 0};
        vecs[4] = '{1, 7, 0, 0, 7, 0, 0, 2'b01, 0, 0, 0, 2'b00, 2'b00, 1, 0, 1};
        vecs[5] = '{0, 7, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0};
        vecs[6] = '{0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 2'b00, 2'b00, 0, 1, 1};
        vecs[7] = '{7, 0, 0, 0, 7, 0, 0, 2'b01, 0, 0, 1, 2'b00, 2'b00, 1, 1, 1};
        vecs[8] = '{7, 0, 0, 0, 7, 0, 0, 2'b10, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0};
        vecs[9] = '{0, 0, 4, 0, 0, 4, 4, 2'b00, 0, 1, 0, 2'b01, 2'b00, 0, 0, 0};

        clear_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        chk("reset_stallCycles", 32'(StallCycles), 32'(0));

        for (int i = 0; i < 10; i++) begin
            Rs1D = vecs[i].rs1d; Rs2D = vecs[i].rs2d; Rs1E = vecs[i].rs1e; Rs2E = vecs[i].rs2e;
            RdE = vecs[i].rde; RdM = vecs[i].rdm; RdW = vecs[i].rdw; ResultSrcE = vecs[i].rse;
            RegWriteM = vecs[i].rwm; RegWriteW = vecs[i].rww; PCSrcE = vecs[i].pcs; MemReqM = 0;
            vec_idx = i;
            step();
        end
        vec_idx = -1;
        clear_inputs();
        chk("vec_loadUseCount", 32'(LoadUseCount), 32'(2));
        chk("vec_flushCount",   32'(FlushCount),   32'(2));

        // Single access then two back-to-back accesses.
        do_reset();
        MemReqM = 1;
        for (int i = 0; i < LAT; i++) step();
        MemReqM = 0;
        step();
        chk("mem_single_stalls", 32'(StallCycles), 32'(2));
        MemReqM = 1;
        for (int i = 0; i < 2 * LAT; i++) step();
        MemReqM = 0;
        step();
        chk("mem_b2b_stalls", 32'(StallCycles), 32'(6));

        // Branch and load-use held off by a memory wait, applied on release.
        do_reset();
        MemReqM = 1; PCSrcE = 1; ResultSrcE = 2'b01; RdE = 7; Rs1D = 7;
        step();
        step();
        chk("held_flushCount",   32'(FlushCount),   32'(0));
        chk("held_loadUseCount", 32'(LoadUseCount), 32'(0));
        step();
        clear_inputs();
        chk("rel_flushCount",   32'(FlushCount),   32'(1));
        chk("rel_loadUseCount", 32'(LoadUseCount), 32'(1));
        chk("rel_stallCycles",  32'(StallCycles),  32'(3));

        // Reset while in WAIT with one stall cycle left.
        MemReqM = 1;
        step();
        reset = 1'b1; MemReqM = 0;
        step();
        reset = 1'b0;
        chk("rst_wait_stallM", 32'(StallM), 32'(0));
        chk("rst_wait_stallF", 32'(StallF), 32'(0));
        chk("rst_wait_counter", 32'(StallCycles), 32'(0));
        step();

        // Saturation of the 8-bit stall counter.
        MemReqM = 1;
        for (int i = 0; i < 400; i++) step();
        MemReqM = 0;
        step();
        chk("sat_stallCycles", 32'(StallCycles), 32'(255));

        // Random traffic with small register numbers to provoke matches.
        for (int i = 0; i < 2000; i++) begin
            Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
            RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
            RdW  = 5'($urandom_range(0, 3));
            ResultSrcE = 2'($urandom_range(0, 3));
            RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
            PCSrcE  = ($urandom_range(0, 5) == 0);
            MemReqM = ($urandom_range(0, 2) == 0);
            reset   = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0;
        clear_inputs();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
